spi_burst_master: RTL and testbench

Parametrised SPI mode-0 master for the ADXL362 accelerometer path; the next generation of the board's single-byte register reader. It runs one framed transaction per START: an instruction+address header, then 0..MAX_BYTES data bytes, either written from a byte stream or read into a byte stream. It sits between the switch/button command decode and the 7-segment/display consumers, and replaces the fixed read-only 8-bit controller.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sclk_gen.sv | 49 ++++
 rtl/spi_burst_master.sv | 215 +++++++++++++++++++++
 tb/tb_spi_burst_master.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the ADXL362 SPI burst master.
// Instruction codes, register addresses and the transaction FSM states.
package spi_pkg;

    localparam logic [7:0] INSTR_WRITE = 8'h0A;
    localparam logic [7:0] INSTR_READ  = 8'h0B;
    localparam logic [7:0] INSTR_FIFO  = 8'h0D;

    localparam logic [7:0] XDATA = 8'h08;
    localparam logic [7:0] YDATA = 8'h09;
    localparam logic [7:0] ZDATA = 8'h0A;

    // Instruction + address header length in bits
    localparam int HDR_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV cycles while EN is high.
// Ports: CLK, RST_N (sync, active low), EN in; SCLK, RISE, FALL out.
// RISE/FALL are one-cycle strobes on the cycle before SCLK changes.
module spi_sclk_gen #(
    parameter int CLK_DIV = 1221
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    output logic SCLK,
    output logic RISE,
    output logic FALL
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    // Strobes depend only on registers, so EN may be derived from them
    // without a combinational loop. cnt is 0 when disabled and
    // CLK_DIV>=2, so no strobe fires while idle.
    assign wrap = (cnt_q == LAST);
    assign RISE = wrap & ~sclk_q;
    assign FALL = wrap & sclk_q;
    assign SCLK = sclk_q;

    always_comb begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (EN) begin
            cnt_d  = wrap ? '0 : cnt_q + CW'(1);
            sclk_d = sclk_q ^ wrap;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_burst_master.sv
// SPI mode-0 burst master: {INSTR,ADDR} header then 0..MAX_BYTES data
// bytes, written from WR_DATA (WR_ACK handshake) or read to RD_DATA.
// In:  CLK, RST_N, START, RW, INSTR, ADDR, LEN, WR_DATA, MISO.
// Out: WR_ACK, RD_DATA, RD_VALID, BUSY, DONE, CS, SCLK, MOSI.
module spi_burst_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = 1221,
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             RW,
    input  logic [7:0]       INSTR,
    input  logic [7:0]       ADDR,
    input  logic [LEN_W-1:0] LEN,
    input  logic [7:0]       WR_DATA,
    output logic             WR_ACK,
    output logic [7:0]       RD_DATA,
    output logic             RD_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic             CS,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO
);

    localparam int BMAX = HDR_BITS + 8 * MAX_BYTES;
    localparam int BW   = $clog2(BMAX);
    localparam int GW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0]    HDR      = BW'(HDR_BITS);
    localparam logic [LEN_W-1:0] MAXL     = LEN_W'(MAX_BYTES);
    localparam logic [GW-1:0]    GAP_LAST = GW'(CLK_DIV - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [BW-1:0] last_q, last_d;
    logic [14:0]   tx_q, tx_d;
    logic          mosi_q, mosi_d;
    logic          rw_q, rw_d;
    logic [6:0]    rx_q, rx_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_ack_q, wr_ack_d;
    logic          done_q, done_d;
    logic          samp_q, samp_d;
    logic          cs_q, cs_d;
    logic          busy_q, busy_d;
    logic [GW-1:0] gap_q, gap_d;

    logic             sclk_en;
    logic             rise;
    logic             fall;
    logic [LEN_W-1:0] len_c;
    logic [BW-1:0]    bit_nx;

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk (
        .CLK  (CLK),
        .RST_N(RST_N),
        .EN   (sclk_en),
        .SCLK (SCLK),
        .RISE (rise),
        .FALL (fall)
    );

    assign len_c  = (LEN > MAXL) ? MAXL : LEN;
    assign bit_nx = bit_q + BW'(1);

    assign cs_d   = !(state_d inside {SETUP, SHIFT, HOLD});
    assign busy_d = (state_d != IDLE);

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        last_d     = last_q;
        tx_d       = tx_q;
        mosi_d     = mosi_q;
        rw_d       = rw_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_ack_d   = 1'b0;
        done_d     = 1'b0;
        samp_d     = 1'b0;
        gap_d      = '0;
        sclk_en    = 1'b0;

        // MISO is taken in the first cycle SCLK is high
        if (samp_q) begin
            rx_d = {rx_q[5:0], MISO};
            if (bit_q[2:0] == 3'd7) begin
                rd_data_d  = {rx_q, MISO};
                rd_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = SETUP;
                    rw_d    = RW;
                    bit_d   = '0;
                    rx_d    = '0;
                    last_d  = BW'(HDR_BITS - 1) + BW'({len_c, 3'b000});
                    mosi_d  = INSTR[7];
                    tx_d    = {INSTR[6:0], ADDR};
                end
            end
            SETUP: begin
                sclk_en = 1'b1;
                if (rise) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sclk_en = 1'b1;
                if (rise) begin
                    samp_d = rw_q && (bit_q >= HDR);
                end
                if (fall) begin
                    if (bit_q == last_q) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d = bit_nx;
                        // Data byte boundary: reload from WR_DATA or idle low
                        if (bit_nx >= HDR && bit_nx[2:0] == 3'd0) begin
                            if (rw_q) begin
                                mosi_d = 1'b0;
                                tx_d   = '0;
                            end else begin
                                mosi_d   = WR_DATA[7];
                                tx_d     = {WR_DATA[6:0], 8'h00};
                                wr_ack_d = 1'b1;
                            end
                        end else begin
                            mosi_d = tx_q[14];
                            tx_d   = {tx_q[13:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                // The divider's next rise strobe marks the end of hold;
                // dropping EN there keeps SCLK low.
                sclk_en = !rise;
                if (rise) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            last_q     <= '0;
            tx_q       <= '0;
            mosi_q     <= 1'b0;
            rw_q       <= 1'b0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            done_q     <= 1'b0;
            samp_q     <= 1'b0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            tx_q       <= tx_d;
            mosi_q     <= mosi_d;
            rw_q       <= rw_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
            done_q     <= done_d;
            samp_q     <= samp_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            gap_q      <= gap_d;
        end
    end

    assign WR_ACK   = wr_ack_q;
    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign CS       = cs_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// Self-checking bench for spi_burst_master (CLK_DIV=4, MAX_BYTES=8).
// Scoreboard of expected MOSI bits and read bytes, plus cycle timing.
module tb_spi_burst_master;
    import spi_pkg::*;

    localparam int CD = 4;
    localparam int MB = 8;
    localparam int LW = 4;

    logic          CLK = 1'b0;
    logic          RST_N, START, RW, MISO;
    logic [7:0]    INSTR, ADDR, WR_DATA;
    logic [LW-1:0] LEN;
    logic          WR_ACK, RD_VALID, BUSY, DONE, CS, SCLK, MOSI;
    logic [7:0]    RD_DATA;

    int tests = 0;
    int fails = 0;

    int cyc, rises, cs_lows, dones, wr_acks, sidx;
    int t_done, t_cs_high, t_cs_low, t_wrack, t_fall, t_idle;
    logic sclk_p, cs_p;

    logic [7:0] resp[$];
    logic [7:0] wr_src[$];
    logic       exp_mosi[$];
    logic       obs_mosi[$];
    logic [7:0] exp_rd[$];
    logic [7:0] obs_rd[$];
    int         rdv_t[$];

    always #5 CLK = ~CLK;

    spi_burst_master #(
        .CLK_DIV  (CD),
        .MAX_BYTES(MB),
        .LEN_W    (LW)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .RW      (RW),
        .INSTR   (INSTR),
        .ADDR    (ADDR),
        .LEN     (LEN),
        .WR_DATA (WR_DATA),
        .WR_ACK  (WR_ACK),
        .RD_DATA (RD_DATA),
        .RD_VALID(RD_VALID),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .CS      (CS),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    // One clock: observe outputs at negedge, act as SPI slave and
    // as the write byte source.
    task automatic step();
        logic [7:0] b;
        @(negedge CLK);
        cyc++;
        if (SCLK && !sclk_p) begin
            rises++;
            obs_mosi.push_back(MOSI);
        end
        if (!SCLK && sclk_p) begin
            sidx++;
            t_fall = cyc;
        end
        if (!CS && cs_p) begin
            cs_lows++;
            sidx = 0;
            t_cs_low = cyc;
        end
        if (CS && !cs_p) t_cs_high = cyc;
        if (RD_VALID) begin
            obs_rd.push_back(RD_DATA);
            rdv_t.push_back(cyc);
        end
        if (WR_ACK) begin
            wr_acks++;
            t_wrack = cyc;
            if (wr_src.size() > 0) void'(wr_src.pop_front());
            WR_DATA = (wr_src.size() > 0) ? wr_src[0] : 8'h00;
        end
        if (DONE) begin
            dones++;
            t_done = cyc;
        end
        sclk_p = SCLK;
        cs_p   = CS;
        if (sidx >= 16 && (sidx - 16) / 8 < resp.size()) begin
            b    = resp[(sidx - 16) / 8];
            MISO = b[7 - (sidx % 8)];
        end else begin
            MISO = 1'b0;
        end
    endtask

    task automatic clear_obs();
        cyc = 0; rises = 0; cs_lows = 0; dones = 0; wr_acks = 0;
        t_done = -1; t_cs_high = -1; t_cs_low = -1;
        t_wrack = -1; t_fall = -1; t_idle = -1;
        exp_mosi.delete(); obs_mosi.delete();
        exp_rd.delete(); obs_rd.delete(); rdv_t.delete();
    endtask

    // Drive a request (cycle 0) and push the expected bit/byte stream.
    task automatic start_frame(input logic rw, input logic [7:0] ins,
                               input logic [7:0] adr, input int len);
        logic [15:0] hdr;
        logic [7:0]  d;
        int          n;
        clear_obs();
        hdr = {ins, adr};
        for (int i = 15; i >= 0; i--) exp_mosi.push_back(hdr[i]);
        n = (len > MB) ? MB : len;
        for (int j = 0; j < n; j++) begin
            if (rw) begin
                exp_rd.push_back(resp[j]);
                for (int i = 0; i < 8; i++) exp_mosi.push_back(1'b0);
            end else begin
                d = wr_src[j];
                for (int i = 7; i >= 0; i--) exp_mosi.push_back(d[i]);
            end
        end
        RW      = rw;
        INSTR   = ins;
        ADDR    = adr;
        LEN     = LW'(len);
        WR_DATA = (wr_src.size() > 0) ? wr_src[0] : 8'h00;
        START   = 1'b1;
    endtask

    task automatic run_to_idle(input int budget);
        int n;
        n = 0;
        while (BUSY && n < budget) begin
            step();
            n++;
        end
        t_idle = cyc;
        tests++;
        if (BUSY) begin
            fails++;
            $display("FAIL idle_timeout: BUSY=%b after %0d cycles, want 0",
                     BUSY, budget);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; START = 1'b0; RW = 1'b0; MISO = 1'b0;
        INSTR = 8'h00; ADDR = 8'h00; LEN = '0; WR_DATA = 8'h00;
        sclk_p = 1'b0; cs_p = 1'b1; sidx = 0;
        clear_obs();
        repeat (3) step();
        tests++;
        if ({CS, SCLK, MOSI, RD_VALID, WR_ACK, BUSY, DONE} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 1000000",
                     {CS, SCLK, MOSI, RD_VALID, WR_ACK, BUSY, DONE});
        end
        tests++;
        if (RD_DATA !== 8'h00) begin
            fails++;
            $display("FAIL reset_rd_data: got %h want 00", RD_DATA);
        end
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_read();
        logic e, o;
        logic [7:0] eb, ob;
        resp = '{8'hA5};
        wr_src.delete();
        start_frame(1'b1, INSTR_READ, XDATA, 1);
        step();
        START = 1'b0;
        tests++;
        if ({CS, BUSY, MOSI} !== 3'b010) begin
            fails++;
            $display("FAIL read_cycle1: CS,BUSY,MOSI got %b want 010",
                     {CS, BUSY, MOSI});
        end
        run_to_idle(400);
        tests++;
        if (obs_mosi.size() != exp_mosi.size()) begin
            fails++;
            $display("FAIL read_mosi_len: got %0d want %0d",
                     obs_mosi.size(), exp_mosi.size());
        end
        while (exp_mosi.size() > 0 && obs_mosi.size() > 0) begin
            e = exp_mosi.pop_front();
            o = obs_mosi.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL read_mosi_bit: got %b want %b", o, e);
            end
        end
        tests++;
        if (obs_rd.size() != 1) begin
            fails++;
            $display("FAIL read_rdv_count: got %0d want 1", obs_rd.size());
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            eb = exp_rd.pop_front();
            ob = obs_rd.pop_front();
            tests++;
            if (ob !== eb) begin
                fails++;
                $display("FAIL read_data: got %h want %h", ob, eb);
            end
        end
        tests++;
        if (rdv_t.size() != 1 || rdv_t[0] != 190) begin
            fails++;
            $display("FAIL read_rdv_cycle: got %0d want 190",
                     (rdv_t.size() > 0) ? rdv_t[0] : -1);
        end
        tests++;
        if (t_done != 197 || t_cs_high != 197 || dones != 1) begin
            fails++;
            $display("FAIL read_done: done@%0d cs@%0d n=%0d want 197/197/1",
                     t_done, t_cs_high, dones);
        end
        tests++;
        if (t_idle != 201) begin
            fails++;
            $display("FAIL read_busy_low: got %0d want 201", t_idle);
        end
    endtask

    task automatic test_burst();
        logic [7:0] eb, ob;
        resp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        start_frame(1'b1, INSTR_READ, XDATA, 6);
        step();
        START = 1'b0;
        run_to_idle(800);
        tests++;
        if (obs_rd.size() != 6) begin
            fails++;
            $display("FAIL burst_count: got %0d want 6", obs_rd.size());
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            eb = exp_rd.pop_front();
            ob = obs_rd.pop_front();
            tests++;
            if (ob !== eb) begin
                fails++;
                $display("FAIL burst_data: got %h want %h", ob, eb);
            end
        end
        for (int i = 1; i < rdv_t.size(); i++) begin
            tests++;
            if (rdv_t[i] - rdv_t[i-1] != 64) begin
                fails++;
                $display("FAIL burst_spacing: got %0d want 64",
                         rdv_t[i] - rdv_t[i-1]);
            end
        end
        tests++;
        if (cs_lows != 1 || t_done != 517) begin
            fails++;
            $display("FAIL burst_frame: cs_lows=%0d done@%0d want 1/517",
                     cs_lows, t_done);
        end
    endtask

    task automatic test_write();
        logic e, o;
        resp.delete();
        wr_src = '{8'h02};
        start_frame(1'b0, INSTR_WRITE, 8'h2D, 1);
        step();
        START = 1'b0;
        run_to_idle(400);
        tests++;
        if (obs_mosi.size() != 24) begin
            fails++;
            $display("FAIL write_mosi_len: got %0d want 24", obs_mosi.size());
        end
        while (exp_mosi.size() > 0 && obs_mosi.size() > 0) begin
            e = exp_mosi.pop_front();
            o = obs_mosi.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL write_mosi_bit: got %b want %b", o, e);
            end
        end
        tests++;
        if (wr_acks != 1 || t_wrack != 129) begin
            fails++;
            $display("FAIL write_ack: n=%0d @%0d want 1 @129",
                     wr_acks, t_wrack);
        end
        tests++;
        if (obs_rd.size() != 0) begin
            fails++;
            $display("FAIL write_no_rdv: got %0d want 0", obs_rd.size());
        end
    endtask

    task automatic test_len_bounds();
        resp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        wr_src.delete();
        start_frame(1'b1, INSTR_READ, YDATA, 0);
        step();
        START = 1'b0;
        run_to_idle(400);
        tests++;
        if (rises != 16 || t_done != 133 || obs_rd.size() != 0) begin
            fails++;
            $display("FAIL len0: rises=%0d done@%0d rdv=%0d want 16/133/0",
                     rises, t_done, obs_rd.size());
        end
        start_frame(1'b1, INSTR_READ, ZDATA, 15);
        step();
        START = 1'b0;
        run_to_idle(1000);
        tests++;
        if (rises != 80 || t_done != 645 || obs_rd.size() != 8) begin
            fails++;
            $display("FAIL len15: rises=%0d done@%0d rdv=%0d want 80/645/8",
                     rises, t_done, obs_rd.size());
        end
    endtask

    task automatic test_start_busy();
        resp.delete();
        start_frame(1'b1, INSTR_READ, XDATA, 0);
        step();
        START = 1'b0;
        while (cyc < 40) step();
        START = 1'b1;
        step();
        START = 1'b0;
        run_to_idle(400);
        repeat (20) step();
        tests++;
        if (cs_lows != 1 || dones != 1 || t_done != 133) begin
            fails++;
            $display("FAIL start_busy: cs_lows=%0d dones=%0d done@%0d want 1/1/133",
                     cs_lows, dones, t_done);
        end
    endtask

    task automatic test_back_to_back();
        int gap_hi, hold;
        start_frame(1'b1, INSTR_READ, XDATA, 0);
        while (cs_lows < 2 && cyc < 400) step();
        START = 1'b0;
        // CS high spans GAP (CLK_DIV) plus the IDLE accept cycle;
        // CS stays low for CLK_DIV cycles after the last SCLK fall.
        gap_hi = t_cs_low - t_cs_high;
        hold   = t_cs_high - t_fall;
        tests++;
        if (cs_lows != 2 || gap_hi != CD + 1) begin
            fails++;
            $display("FAIL b2b_gap: cs_lows=%0d cs_high=%0d want 2/%0d",
                     cs_lows, gap_hi, CD + 1);
        end
        tests++;
        if (hold != CD) begin
            fails++;
            $display("FAIL b2b_hold: got %0d want %0d", hold, CD);
        end
        run_to_idle(400);
        repeat (20) step();
        tests++;
        if (cs_lows != 2 || dones != 2) begin
            fails++;
            $display("FAIL b2b_count: cs_lows=%0d dones=%0d want 2/2",
                     cs_lows, dones);
        end
    endtask

    task automatic test_abort();
        logic [7:0] eb, ob;
        resp = '{8'hA5};
        start_frame(1'b1, INSTR_READ, XDATA, 1);
        step();
        START = 1'b0;
        while (rises < 10 && cyc < 200) step();
        tests++;
        if (cyc != 77) begin
            fails++;
            $display("FAIL abort_bit9_rise: got %0d want 77", cyc);
        end
        RST_N = 1'b0;
        step();
        tests++;
        if ({CS, SCLK, MOSI, BUSY, DONE, RD_VALID} !== 6'b100000) begin
            fails++;
            $display("FAIL abort_outputs: got %b want 100000",
                     {CS, SCLK, MOSI, BUSY, DONE, RD_VALID});
        end
        RST_N = 1'b1;
        clear_obs();
        repeat (300) step();
        tests++;
        if (dones != 0 || obs_rd.size() != 0 || cs_lows != 0) begin
            fails++;
            $display("FAIL abort_quiet: dones=%0d rdv=%0d cs=%0d want 0/0/0",
                     dones, obs_rd.size(), cs_lows);
        end
        resp = '{8'h3C};
        start_frame(1'b1, INSTR_READ, XDATA, 1);
        step();
        START = 1'b0;
        run_to_idle(400);
        tests++;
        if (obs_rd.size() != 1 || t_done != 197) begin
            fails++;
            $display("FAIL abort_restart: rdv=%0d done@%0d want 1/197",
                     obs_rd.size(), t_done);
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            eb = exp_rd.pop_front();
            ob = obs_rd.pop_front();
            tests++;
            if (ob !== eb) begin
                fails++;
                $display("FAIL abort_restart_data: got %h want %h", ob, eb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_burst();
        test_write();
        test_len_bounds();
        test_start_busy();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
